alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single-cycle ALU between two requesters, for example the execute stage and a multi-cycle helper unit.
- Each requester issues an operand pair and a 3-bit ALU control code over a valid/ready handshake.
- The arbiter grants round-robin, drives the ALU from registered operands, captures the result and zero flag, and returns them over a per-requester response handshake.
- One operation is in flight at a time.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- CTRL_WIDTH, 3, ALU control code width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op1  in  DATA_WIDTH  operand 1, signed.
- req0_op2  in  DATA_WIDTH  operand 2, signed.
- req0_ctrl  in  CTRL_WIDTH  ALU code: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- req1_valid, req1_ready, req1_op1, req1_op2, req1_ctrl  same as requester 0.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 consumes result.
- rsp1_valid  out  1  result for requester 1 available.
- rsp1_ready  in  1  requester 1 consumes result.
- rsp_result  out  DATA_WIDTH  captured ALU result, shared by both responses.
- rsp_zero  out  1  captured ALU zero flag.
- aluop1  out  DATA_WIDTH  to ALU.
- aluop2  out  DATA_WIDTH  to ALU.
- alucontrol  out  CTRL_WIDTH  to ALU.
- aluresult  in  DATA_WIDTH  from ALU, combinational.
- zero  in  1  from ALU.

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - state IDLE, last_grant = 1
  - op registers 0, ctrl register 000, owner register 0
  - rsp_result 0, rsp_zero 0, rsp0_valid 0, rsp1_valid 0
  - req0_ready 0, req1_ready 0
- The FSM has three states:
  - IDLE: grant is computed combinationally from the valids.
    - Only reqN_valid high: grant N.
    - Both high: grant the requester not equal to last_grant.
    - reqN_ready = (state==IDLE) && grant==N. At most one ready is high.
    - Ready depends on valid; valid must not depend on ready.
    - On a handshake, capture op1/op2/ctrl, set owner=N and last_grant=N, go to EXEC.
  - EXEC: drive aluop1/aluop2/alucontrol from the registers for exactly one cycle.
    - At the clock edge, capture aluresult into rsp_result and zero into rsp_zero, then go to RESP.
  - RESP: rsp<owner>_valid = 1 and the other response valid = 0.
    - rsp_result/rsp_zero are held stable.
    - On rsp<owner>_ready go to IDLE; no new grant in that same cycle.
    - Without ready, stay in RESP indefinitely; back-pressure is allowed.
- Outside EXEC, aluop1 = 0, aluop2 = 0, alucontrol = 000.
- Latency: handshake at edge t, rsp valid from edge t+2. Minimum issue interval is 3 cycles per operation.
- Control codes 100/110/111 are forwarded unchanged. The ALU returns 0, so rsp_result = 0 and rsp_zero = 1. These codes are not an error.
- Requester inputs are ignored outside the IDLE handshake. Changes to reqN_op* after acceptance have no effect.
- Reset mid-operation, in EXEC or RESP, aborts to IDLE. The pending response is discarded, never presented, and last_grant returns to 1.
- A requester that holds valid while losing arbitration is served in the next IDLE cycle. Starvation is impossible.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1, each 16 bits.
  - Each increments on its requester's accepted handshake and saturates at 16'hFFFF.
  - Both reset to 0.
  - Other behaviour is unchanged.
- Undefined: ports and counters are absent and the interface is exactly as listed.

Test Plan:
- Single request: req0 add, op1=7, op2=5. Expect req0_ready the same cycle, alucontrol=000 in EXEC, then rsp0_valid with rsp_result=12 and rsp_zero=0, 2 cycles after acceptance. rsp1_valid stays 0.
- Simultaneous requests from reset: req0 sub 9-9 and req1 slt -3<2 held valid. Expect requester 0 served first with result 0 and zero 1, then requester 1 with result 1 and zero 0. Then with both held again, expect strict alternation 0,1,0,1 over 4 grants.
- Back-pressure: rsp1_ready held low for 5 cycles. Expect rsp1_valid and rsp_result held stable, req0_ready=0 throughout, and a new grant only in the cycle after rsp1_ready.
- Illegal code: req1_ctrl=111, op1=op2=32'hFFFFFFFF. Expect rsp_result=0 and rsp_zero=1.
- Async reset asserted mid-EXEC, between edges. Expect all outputs at reset values immediately, no rsp valid afterwards, and the next simultaneous request granted to requester 0.
- With ALU_ARB_STATS_EN defined: 3 grants to req0 and 1 to req1. Expect grant_cnt0=3 and grant_cnt1=1. Preloading to 16'hFFFE then 3 grants gives 16'hFFFF.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one single-cycle ALU between two valid/ready requesters.
// Optional ALU_ARB_STATS_EN adds saturating 16-bit per-requester grant counters.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_op1,
  input  logic [DATA_WIDTH-1:0] req0_op2,
  input  logic [CTRL_WIDTH-1:0] req0_ctrl,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_op1,
  input  logic [DATA_WIDTH-1:0] req1_op2,
  input  logic [CTRL_WIDTH-1:0] req1_ctrl,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic [DATA_WIDTH-1:0] aluop1,
  output logic [DATA_WIDTH-1:0] aluop2,
  output logic [CTRL_WIDTH-1:0] alucontrol,
  input  logic [DATA_WIDTH-1:0] aluresult,
  input  logic                  zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]           grant_cnt0,
  output logic [15:0]           grant_cnt1
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t                state;
  logic                  last_grant, owner;
  logic [DATA_WIDTH-1:0] op1_r, op2_r;
  logic [CTRL_WIDTH-1:0] ctrl_r;
  logic                  idle, take;
  assign idle       = state == IDLE;
  // Contention goes to whoever was not served last.
  assign req0_ready = idle && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = idle && req1_valid && (!req0_valid || !last_grant);
  assign take       = req0_ready || req1_ready;
  assign aluop1     = state == EXEC ? op1_r : '0;
  assign aluop2     = state == EXEC ? op2_r : '0;
  assign alucontrol = state == EXEC ? ctrl_r : '0;
  assign rsp0_valid = state == RESP && !owner;
  assign rsp1_valid = state == RESP && owner;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op1_r      <= '0;
      op2_r      <= '0;
      ctrl_r     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take) begin
          op1_r      <= req1_ready ? req1_op1 : req0_op1;
          op2_r      <= req1_ready ? req1_op2 : req0_op2;
          ctrl_r     <= req1_ready ? req1_ctrl : req0_ctrl;
          owner      <= req1_ready;
          last_grant <= req1_ready;
          state      <= EXEC;
        end
        EXEC: begin
          rsp_result <= aluresult;
          rsp_zero   <= zero;
          state      <= RESP;
        end
        RESP: if (owner ? rsp1_ready : rsp0_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif
endmodule
